// File: rtl/picobello_pkg.sv
// Shared types and defaults for the picobello tile-to-tile link buffers.
// Performance snapshot layout and default buffer sizing live here.
package picobello_pkg;

  localparam int unsigned LinkBufDepth     = 2;
  localparam int unsigned LinkPerfCntWidth = 32;
  localparam int unsigned LinkUsageWidth   = $clog2(LinkBufDepth + 1);

  typedef struct packed {
    logic [LinkPerfCntWidth-1:0] flit_cnt;
    logic [LinkPerfCntWidth-1:0] stall_cnt;
    logic [LinkUsageWidth-1:0]   watermark;
  } link_perf_t;

endpackage

// File: rtl/pb_sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
// Clear wins over a same-cycle enable; the count sticks at all-ones.
module pb_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/floo_link_buffer.sv
// Registered FIFO between a router output port and the neighbour tile input,
// with flit/stall counters and an occupancy watermark for link profiling.
module floo_link_buffer
  import picobello_pkg::*;
#(
  parameter type         flit_t   = logic,
  parameter int unsigned Depth    = LinkBufDepth,
  parameter int unsigned CntWidth = 32,
  localparam int unsigned UsageW  = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  flit_t               in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output flit_t               out_data_o,
  output logic [UsageW-1:0]   usage_o,
  output logic [CntWidth-1:0] flit_cnt_o,
  output logic [CntWidth-1:0] stall_cnt_o,
  output logic [UsageW-1:0]   watermark_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  if (Depth < 2) begin : gen_depth_check
    $error("floo_link_buffer: Depth must be at least 2");
  end

  flit_t             mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_d, rd_ptr_q;
  logic [UsageW-1:0] usage_d, usage_q;
  logic [UsageW-1:0] wm_d, wm_q;
  logic              push, pop, stall;

  // Handshake flags depend only on the occupancy register, never on the
  // opposite side's inputs, so the buffer breaks both timing paths.
  assign in_ready_o  = (usage_q < UsageW'(Depth));
  assign out_valid_o = (usage_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign push  = in_valid_i && in_ready_o;
  assign pop   = out_valid_o && out_ready_i;
  assign stall = out_valid_o && !out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   usage_d = usage_q + UsageW'(1);
      2'b01:   usage_d = usage_q - UsageW'(1);
      default: usage_d = usage_q;
    endcase
  end

  // A clear restarts the peak from what is buffered right now.
  always_comb begin
    wm_d = wm_q;
    if (clear_i) begin
      wm_d = usage_q;
    end else if (usage_d > wm_q) begin
      wm_d = usage_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      wm_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
      wm_q     <= wm_d;
    end
  end

  // Payload storage is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  pb_sat_counter #(
    .Width (CntWidth)
  ) i_flit_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (pop),
    .cnt_o   (flit_cnt_o)
  );

  pb_sat_counter #(
    .Width (CntWidth)
  ) i_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (stall),
    .cnt_o   (stall_cnt_o)
  );

  assign usage_o     = usage_q;
  assign watermark_o = wm_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    usage_q <= UsageW'(Depth));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_floo_link_buffer.sv
// Bench for floo_link_buffer: a Depth=2/CntWidth=4 and a Depth=3/CntWidth=8
// instance share one stimulus stream and are checked against queue models.
module tb_floo_link_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, in_valid, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_usage, a_wm;
  logic [3:0] a_flit, a_stall;

  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_usage, b_wm;
  logic [7:0] b_flit, b_stall;

  floo_link_buffer #(
    .flit_t   (logic [7:0]),
    .Depth    (2),
    .CntWidth (4)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (a_in_ready),
    .in_data_i   (in_data),
    .out_valid_o (a_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (a_out_data),
    .usage_o     (a_usage),
    .flit_cnt_o  (a_flit),
    .stall_cnt_o (a_stall),
    .watermark_o (a_wm)
  );

  floo_link_buffer #(
    .flit_t   (logic [7:0]),
    .Depth    (3),
    .CntWidth (8)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (b_out_data),
    .usage_o     (b_usage),
    .flit_cnt_o  (b_flit),
    .stall_cnt_o (b_stall),
    .watermark_o (b_wm)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one queue plus counters per instance.
  int unsigned mdepth [2] = '{2, 3};
  int unsigned mmax   [2] = '{15, 255};
  logic [7:0]  mq     [2][$];
  int unsigned mflit  [2];
  int unsigned mstall [2];
  int unsigned mwm    [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      mflit[i]  = 0;
      mstall[i] = 0;
      mwm[i]    = 0;
    end
  endtask

  // Advance one clock edge, updating the model from the inputs seen before it.
  task automatic step();
    bit          push [2];
    bit          pop  [2];
    bit          stl  [2];
    int unsigned sz   [2];
    logic [7:0]  d;
    bit          clr;
    d   = in_data;
    clr = clear;
    for (int i = 0; i < 2; i++) begin
      sz[i]   = mq[i].size();
      push[i] = in_valid && (sz[i] < mdepth[i]);
      pop[i]  = out_ready && (sz[i] > 0);
      stl[i]  = (sz[i] > 0) && !out_ready;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pop[i]) void'(mq[i].pop_front());
      if (push[i]) mq[i].push_back(d);
      if (clr) begin
        mflit[i]  = 0;
        mstall[i] = 0;
        mwm[i]    = sz[i];
      end else begin
        if (pop[i] && mflit[i] < mmax[i]) mflit[i]++;
        if (stl[i] && mstall[i] < mmax[i]) mstall[i]++;
        if (mq[i].size() > mwm[i]) mwm[i] = mq[i].size();
      end
    end
    #1;
  endtask

  task automatic drain_and_clear();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear     = 1'b0;
    for (int c = 0; c < 8; c++) step();
    out_ready = 1'b0;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_valid: got a=%b b=%b expected 0", a_out_valid, b_out_valid);
    end
    n_cmp++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_ready: got a=%b b=%b expected 1", a_in_ready, b_in_ready);
    end
    n_cmp++; if (a_usage !== 2'd0 || a_flit !== 4'd0 || a_stall !== 4'd0 || a_wm !== 2'd0) begin
      n_fail++; $display("[TB] FAIL reset_a_state: got usage=%0h flit=%0h stall=%0h wm=%0h expected all 0",
                         a_usage, a_flit, a_stall, a_wm);
    end
    n_cmp++; if (b_usage !== 2'd0 || b_flit !== 8'd0 || b_stall !== 8'd0 || b_wm !== 2'd0) begin
      n_fail++; $display("[TB] FAIL reset_b_state: got usage=%0h flit=%0h stall=%0h wm=%0h expected all 0",
                         b_usage, b_flit, b_stall, b_wm);
    end
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_back_to_back();
    drain_and_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      n_cmp++; if (a_in_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL b2b_ready k=%0d: got %b expected 1", k, a_in_ready);
      end
      step();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(k + 1)) begin
        n_fail++; $display("[TB] FAIL b2b_data k=%0d: got valid=%b data=%0h expected valid=1 data=%0h",
                           k, a_out_valid, a_out_data, k + 1);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (a_flit !== 4'd10 || a_stall !== 4'd0 || a_out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_counts: got flit=%0d stall=%0d valid=%b expected 10 0 0",
                         a_flit, a_stall, a_out_valid);
    end
    n_cmp++; if (b_flit !== 8'(mflit[1]) || b_stall !== 8'd0) begin
      n_fail++; $display("[TB] FAIL b2b_b_counts: got flit=%0d stall=%0d expected %0d 0", b_flit, b_stall, mflit[1]);
    end
  endtask

  task automatic test_backpressure();
    drain_and_clear();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 8'($urandom);
      n_cmp++; if (a_in_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL bp_ready_push%0d: got %b expected 1", k, a_in_ready);
      end
      step();
    end
    in_data = 8'($urandom);
    n_cmp++; if (a_in_ready !== 1'b0 || a_usage !== 2'd2 || a_wm !== 2'd2) begin
      n_fail++; $display("[TB] FAIL bp_full: got ready=%b usage=%0d wm=%0d expected 0 2 2", a_in_ready, a_usage, a_wm);
    end
    for (int h = 0; h < 3; h++) begin
      step();
      n_cmp++; if (a_stall !== 4'(mstall[0]) || a_in_ready !== 1'b0 || a_usage !== 2'd2) begin
        n_fail++; $display("[TB] FAIL bp_hold%0d: got stall=%0d ready=%b usage=%0d expected %0d 0 2",
                           h, a_stall, a_in_ready, a_usage, mstall[0]);
      end
    end
    out_ready = 1'b1;
    n_cmp++; if (a_out_data !== mq[0][0]) begin
      n_fail++; $display("[TB] FAIL bp_head: got %0h expected %0h", a_out_data, mq[0][0]);
    end
    step();
    n_cmp++; if (a_usage !== 2'd1) begin
      n_fail++; $display("[TB] FAIL bp_full_pop_refuse: got usage=%0d expected 1", a_usage);
    end
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (a_usage !== 2'(mq[0].size()) || a_usage !== 2'd2) begin
      n_fail++; $display("[TB] FAIL bp_third_accept: got usage=%0d expected 2", a_usage);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== mq[0][0]) begin
        n_fail++; $display("[TB] FAIL bp_drain%0d: got valid=%b data=%0h expected 1 %0h",
                           c, a_out_valid, a_out_data, mq[0][0]);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    int unsigned accepted;
    int unsigned pops;
    drain_and_clear();
    accepted = 0;
    pops     = 0;
    for (int cyc = 0; cyc < 2000 && (accepted < 100 || mq[1].size() > 0); cyc++) begin
      in_valid  = (accepted < 100);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (mq[1].size() > 0 && out_ready) begin
        pops++;
        n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== mq[1][0]) begin
          n_fail++; $display("[TB] FAIL wrap_order cyc=%0d: got valid=%b data=%0h expected 1 %0h",
                             cyc, b_out_valid, b_out_data, mq[1][0]);
        end
      end
      n_cmp++; if (b_usage !== 2'(mq[1].size()) || b_in_ready !== (mq[1].size() < 3)) begin
        n_fail++; $display("[TB] FAIL wrap_usage cyc=%0d: got usage=%0d ready=%b expected %0d",
                           cyc, b_usage, b_in_ready, mq[1].size());
      end
      if (in_valid && mq[1].size() < 3) accepted++;
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (accepted != 100 || pops != 100) begin
      n_fail++; $display("[TB] FAIL wrap_budget: got accepted=%0d popped=%0d expected 100 100", accepted, pops);
    end
    n_cmp++; if (b_flit !== 8'd100 || b_out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wrap_count: got flit=%0d valid=%b expected 100 0", b_flit, b_out_valid);
    end
    n_cmp++; if (b_stall !== 8'(mstall[1]) || b_wm !== 2'(mwm[1])) begin
      n_fail++; $display("[TB] FAIL wrap_perf: got stall=%0d wm=%0d expected %0d %0d", b_stall, b_wm, mstall[1], mwm[1]);
    end
  endtask

  task automatic test_saturation();
    drain_and_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    n_cmp++; if (a_flit !== 4'd15) begin
      n_fail++; $display("[TB] FAIL sat_flit: got %0d expected 15", a_flit);
    end
    n_cmp++; if (b_flit !== 8'd20) begin
      n_fail++; $display("[TB] FAIL sat_b_flit: got %0d expected 20", b_flit);
    end
  endtask

  task automatic test_clear_mid_traffic();
    logic [7:0] pushed;
    drain_and_clear();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    pushed    = in_data;
    step();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (a_flit !== 4'd0 || a_stall !== 4'd0 || a_wm !== 2'd1) begin
      n_fail++; $display("[TB] FAIL clr_perf: got flit=%0d stall=%0d wm=%0d expected 0 0 1", a_flit, a_stall, a_wm);
    end
    n_cmp++; if (a_usage !== 2'd1 || a_out_valid !== 1'b1 || a_out_data !== pushed) begin
      n_fail++; $display("[TB] FAIL clr_keep: got usage=%0d valid=%b data=%0h expected 1 1 %0h",
                         a_usage, a_out_valid, a_out_data, pushed);
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (a_flit !== 4'd1 || a_out_valid !== 1'b0 || a_wm !== 2'd1) begin
      n_fail++; $display("[TB] FAIL clr_deliver: got flit=%0d valid=%b wm=%0d expected 1 0 1", a_flit, a_out_valid, a_wm);
    end
  endtask

  task automatic test_reset_mid_operation();
    drain_and_clear();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (2) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (a_usage !== 2'd2 || a_stall === 4'd0) begin
      n_fail++; $display("[TB] FAIL rstmid_pre: got usage=%0d stall=%0d expected 2 nonzero", a_usage, a_stall);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_usage !== 2'd0) begin
      n_fail++; $display("[TB] FAIL rstmid_flags: got valid=%b ready=%b usage=%0d expected 0 1 0",
                         a_out_valid, a_in_ready, a_usage);
    end
    n_cmp++; if (a_flit !== 4'd0 || a_stall !== 4'd0 || a_wm !== 2'd0 || b_flit !== 8'd0 || b_stall !== 8'd0) begin
      n_fail++; $display("[TB] FAIL rstmid_cnt: got a=%0d/%0d/%0d b=%0d/%0d expected all 0",
                         a_flit, a_stall, a_wm, b_flit, b_stall);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    step();
    in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== mq[0][0] || a_usage !== 2'd1) begin
      n_fail++; $display("[TB] FAIL rstmid_resume: got valid=%b data=%0h usage=%0d expected 1 %0h 1",
                         a_out_valid, a_out_data, a_usage, mq[0][0]);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_saturation();
    test_clear_mid_traffic();
    test_reset_mid_operation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
